// File: rtl/mips_pkg.sv
// Shared constants for the MIPS control path: opcode/funct encodings, ALUOp and
// ALUControl codes, and the multicycle controller state encoding.
`timescale 1ns/1ps
package mips_pkg;

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10,
    AluOpRsvd  = 2'b11
  } aluop_t;

  localparam logic [2:0] AluCtlAdd = 3'b010;
  localparam logic [2:0] AluCtlSub = 3'b110;
  localparam logic [2:0] AluCtlAnd = 3'b000;
  localparam logic [2:0] AluCtlOr  = 3'b001;
  localparam logic [2:0] AluCtlSlt = 3'b111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiExec = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps ALUOp (and Funct for R-type) to ALUControl.
// Shared between the single-cycle and multicycle control units.
//   aluop      - ALU operation class from the main controller
//   funct      - instruction funct field
//   alucontrol - ALU function select
`timescale 1ns/1ps
module alu_decoder
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = AluCtlAdd;
    case (aluop)
      AluOpSub:   alucontrol = AluCtlSub;
      AluOpFunct: begin
        case (funct)
          FunctAdd: alucontrol = AluCtlAdd;
          FunctSub: alucontrol = AluCtlSub;
          FunctAnd: alucontrol = AluCtlAnd;
          FunctOr:  alucontrol = AluCtlOr;
          FunctSlt: alucontrol = AluCtlSlt;
          default:  alucontrol = AluCtlAdd;
        endcase
      end
      default:    alucontrol = AluCtlAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM controller for the multicycle MIPS datapath (shared memory, one ALU).
// Ports:
//   CLK, Reset (async, active low)
//   Op, Funct, Zero, MemReady         - decode inputs and memory handshake
//   PCEn, IorD, MemWrite, IRWrite,
//   RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB, PCSrc           - datapath controls
//   ALUControl                        - ALU function select
//   IllegalOp                         - one-cycle pulse on unsupported opcode
//   State                             - current state (debug)
`timescale 1ns/1ps
module multicycle_control_unit
  import mips_pkg::*;
#(
  parameter int unsigned OP_WIDTH    = 6,
  parameter int unsigned FUNCT_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [OP_WIDTH-1:0]    Op,
  input  logic [FUNCT_WIDTH-1:0] Funct,
  input  logic                   Zero,
  input  logic                   MemReady,
  output logic                   PCEn,
  output logic                   IorD,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             PCSrc,
  output logic [2:0]             ALUControl,
  output logic                   IllegalOp,
  output logic [3:0]             State
);

  state_t state_q, state_d;
  aluop_t aluop;
  logic   pcwrite, branch, memwrite_raw, irwrite_raw, regwrite_raw, illegal_raw;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = StFetch;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    IorD         = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    PCSrc        = 2'b00;
    aluop        = AluOpAdd;
    case (state_q)
      StFetch: begin
        ALUSrcB     = 2'b01;
        irwrite_raw = MemReady;
        pcwrite     = MemReady;
        state_d     = MemReady ? StDecode : StFetch;
      end
      StDecode: begin
        // ALU precomputes the branch target into ALUOut.
        ALUSrcB = 2'b11;
        case (Op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiExec;
          OpJ:        state_d = StJump;
          default: begin
            state_d     = StFetch;
            illegal_raw = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        IorD    = 1'b1;
        state_d = MemReady ? StMemWb : StMemRead;
      end
      StMemWb: begin
        MemtoReg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      StMemWrite: begin
        // Strobe stays up across the whole stall.
        IorD         = 1'b1;
        memwrite_raw = 1'b1;
        state_d      = MemReady ? StFetch : StMemWrite;
      end
      StExecute: begin
        ALUSrcA = 1'b1;
        aluop   = AluOpFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        RegDst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      StBranch: begin
        ALUSrcA = 1'b1;
        aluop   = AluOpSub;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      StAddiExec: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = StAddiWb;
      end
      StAddiWb: regwrite_raw = 1'b1;
      StJump: begin
        PCSrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  // Reset gates the write enables combinationally so nothing commits mid-reset.
  assign PCEn      = Reset & (pcwrite | (branch & Zero));
  assign IRWrite   = Reset & irwrite_raw;
  assign MemWrite  = Reset & memwrite_raw;
  assign RegWrite  = Reset & regwrite_raw;
  assign IllegalOp = Reset & illegal_raw;
  assign State     = state_q;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (Funct),
    .alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
`timescale 1ns/1ps
module tb_multicycle_control_unit;
  import mips_pkg::*;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] Op, Funct;
  logic       Zero, MemReady;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  multicycle_control_unit #(.OP_WIDTH(6), .FUNCT_WIDTH(6)) dut (
    .CLK(CLK), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .ALUControl(ALUControl), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] state;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluctl;
    logic       illegal;
  } obs_t;

  obs_t  sb_q[$];
  string nm_q[$];
  int    total = 0;
  int    bad   = 0;

  function automatic obs_t observe();
    obs_t o;
    o = '{State, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
          ALUSrcB, PCSrc, ALUControl, IllegalOp};
    return o;
  endfunction

  function automatic logic [2:0] funct_ctl(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // Expected control word for one cycle in a given phase of an instruction.
  function automatic obs_t model(input state_t ph, input logic [5:0] op, input logic [5:0] f,
                                 input logic mr, input logic z);
    obs_t e;
    e        = '0;
    e.state  = ph;
    e.aluctl = 3'b010;
    case (ph)
      StFetch:    begin e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
      StDecode:   begin e.alusrcb = 2'b11; e.illegal = !is_legal(op); end
      StMemAdr:   begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      StMemRead:  e.iord = 1'b1;
      StMemWb:    begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      StMemWrite: begin e.iord = 1'b1; e.memwrite = 1'b1; end
      StExecute:  begin e.alusrca = 1'b1; e.aluctl = funct_ctl(f); end
      StAluWb:    begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      StBranch:   begin e.alusrca = 1'b1; e.aluctl = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
      StAddiExec: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      StAddiWb:   e.regwrite = 1'b1;
      StJump:     begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default:    e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // One clock cycle of stimulus; expected outputs go to the scoreboard.
  task automatic step(input state_t ph, input logic [5:0] op, input logic [5:0] f,
                      input logic mr, input logic z);
    @(posedge CLK);
    #1;
    Op = op; Funct = f; MemReady = mr; Zero = z;
    sb_q.push_back(model(ph, op, f, mr, z));
    nm_q.push_back(ph.name());
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z,
                           input int fstall, input int mstall);
    for (int i = 0; i < fstall; i++) step(StFetch, op, f, 1'b0, z);
    step(StFetch, op, f, 1'b1, z);
    step(StDecode, op, f, 1'($urandom_range(0, 1)), z);
    case (op)
      OpLw: begin
        step(StMemAdr, op, f, 1'($urandom_range(0, 1)), z);
        for (int i = 0; i < mstall; i++) step(StMemRead, op, f, 1'b0, z);
        step(StMemRead, op, f, 1'b1, z);
        step(StMemWb, op, f, 1'($urandom_range(0, 1)), z);
      end
      OpSw: begin
        step(StMemAdr, op, f, 1'($urandom_range(0, 1)), z);
        for (int i = 0; i < mstall; i++) step(StMemWrite, op, f, 1'b0, z);
        step(StMemWrite, op, f, 1'b1, z);
      end
      OpRtype: begin
        step(StExecute, op, f, 1'($urandom_range(0, 1)), z);
        step(StAluWb, op, f, 1'($urandom_range(0, 1)), z);
      end
      OpAddi: begin
        step(StAddiExec, op, f, 1'($urandom_range(0, 1)), z);
        step(StAddiWb, op, f, 1'($urandom_range(0, 1)), z);
      end
      OpBeq: step(StBranch, op, f, 1'($urandom_range(0, 1)), z);
      OpJ:   step(StJump, op, f, 1'($urandom_range(0, 1)), z);
      default: ;
    endcase
  endtask

  // Monitor: the DUT presents a control word every cycle; compare mid-cycle.
  initial begin : monitor
    obs_t  want;
    string nm;
    forever begin
      @(negedge CLK);
      if (sb_q.size() != 0) begin
        want = sb_q.pop_front();
        nm   = nm_q.pop_front();
        check(nm, 32'(observe()), 32'(want));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] ops[6]    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  logic [5:0] functs[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin : stim
    logic [5:0] rop, rf;
    Reset = 1'b0; MemReady = 1'b1; Zero = 1'b0; Op = 6'b0; Funct = 6'b0;
    #12;
    check("rst_state", 32'(State), 32'(StFetch));
    check("rst_irwrite", 32'(IRWrite), 32'd0);
    check("rst_pcen", 32'(PCEn), 32'd0);
    check("rst_wren", 32'({MemWrite, RegWrite, IllegalOp}), 32'd0);
    check("rst_alusrcb", 32'(ALUSrcB), 32'(2'b01));
    @(negedge CLK);
    MemReady = 1'b0;
    Reset    = 1'b1;

    run_instr(OpLw, 6'b0, 1'b0, 0, 0);
    run_instr(OpSw, 6'b0, 1'b0, 0, 3);
    run_instr(OpRtype, FunctSlt, 1'b0, 0, 0);
    run_instr(OpBeq, 6'b0, 1'b1, 0, 0);
    run_instr(OpBeq, 6'b0, 1'b0, 0, 0);
    run_instr(6'b111111, 6'b0, 1'b0, 0, 0);
    run_instr(OpAddi, 6'b0, 1'b0, 1, 0);
    run_instr(OpJ, 6'b0, 1'b0, 0, 0);

    // Reset dropped during MEMWB: write enables must fall immediately.
    step(StFetch, OpLw, 6'b0, 1'b1, 1'b0);
    step(StDecode, OpLw, 6'b0, 1'b1, 1'b0);
    step(StMemAdr, OpLw, 6'b0, 1'b1, 1'b0);
    step(StMemRead, OpLw, 6'b0, 1'b1, 1'b0);
    step(StMemWb, OpLw, 6'b0, 1'b1, 1'b0);
    @(negedge CLK);
    #1;
    Reset = 1'b0;
    #1;
    check("midrst_regwrite", 32'(RegWrite), 32'd0);
    check("midrst_state", 32'(State), 32'(StFetch));
    check("midrst_irwrite_pcen", 32'({IRWrite, PCEn}), 32'd0);
    check("midrst_memtoreg", 32'(MemtoReg), 32'd0);
    @(posedge CLK);
    #1;
    MemReady = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    run_instr(OpLw, 6'b0, 1'b0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int k;
      k = int'($urandom_range(0, 6));
      if (k == 6) begin
        rop = 6'($urandom);
        if (is_legal(rop)) rop = 6'b111111;
      end else begin
        rop = ops[k];
      end
      rf = ($urandom_range(0, 5) == 5) ? 6'($urandom) : functs[$urandom_range(0, 4)];
      run_instr(rop, rf, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge CLK);
    #2;
    if (sb_q.size() != 0) check("drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore FSM controller that sequences a multicycle MIPS datapath: one shared memory, one ALU, IR/A/B/ALUOut registers.
- Decodes Op/Funct and drives per-state datapath controls.
- Stalls on a memory-ready handshake.
- Replaces the combinational single-cycle control unit when the core moves to the multicycle build.

Parameters:
OP_WIDTH, 6, opcode field width (Instr[31:26])
FUNCT_WIDTH, 6, funct field width (Instr[5:0])

Ports:
CLK  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
Op  input  6  opcode from instruction register
Funct  input  6  funct field from instruction register
Zero  input  1  ALU zero flag
MemReady  input  1  memory access complete this cycle
PCEn  output  1  PC load enable = PCWrite | (Branch & Zero)
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
RegDst  output  1  write register: 0=rt, 1=rd
MemtoReg  output  1  writeback source: 0=ALUOut, 1=Data
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
IllegalOp  output  1  one-cycle pulse on unsupported opcode
State  output  4  current state encoding (debug)

Behaviour:
- Reset low: state <= FETCH asynchronously. While Reset is low, every write enable (PCEn, IRWrite, MemWrite, RegWrite) and IllegalOp is forced 0. All other outputs take the FETCH values.
- Outputs are Moore, decoded from state only. Exceptions: PCEn uses Zero in BRANCH. ALUControl uses Funct when ALUOp=10.
- Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=PCWrite=MemReady.
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target). Next state by Op:
  - LW/SW -> MEMADR; RTYPE -> EXECUTE; BEQ -> BRANCH; ADDI -> ADDIEXEC; J -> JUMP.
  - Any other opcode -> FETCH, with IllegalOp=1 for this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEMREAD; SW -> MEMWRITE.
- MEMREAD: IorD=1. Hold while MemReady=0; -> MEMWB when MemReady=1.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. -> FETCH.
- MEMWRITE: IorD=1, MemWrite=1, held for the whole stall. -> FETCH on the cycle MemReady=1.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, PCEn=Zero. -> FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. -> FETCH.
- JUMP: PCSrc=10, PCWrite=1. -> FETCH.
- ALU decode:
  - ALUOp 00 -> 010; ALUOp 01 -> 110.
  - ALUOp 10 by Funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other -> 010.
  - ALUOp 11 -> 010.
- Unused state encodings -> FETCH on the next edge.
- Latency with MemReady always 1: LW 5 cycles, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3.
- Reset asserted mid-instruction: write enables drop to 0 in the same cycle (combinational). No partial writeback occurs on the next edge.

Decomposition:
- Shared package (mips_pkg): opcode/funct constants, ALUOp codes, ALUControl codes, state encodings.
- Sub-module alu_decoder: combinational ALUOp+Funct -> ALUControl, reusable by the single-cycle control.

Test Plan:
- Reset low mid-MEMWB, then release -> RegWrite=0 at once; State=FETCH; first post-release cycle has IRWrite=1, PCEn=1 (MemReady=1).
- LW (Op=100011), MemReady=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1, MemtoReg=1 in cycle 5 only.
- SW with MemReady low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, then FETCH; RegWrite never asserted.
- RTYPE with Funct=101010 -> ALUControl=111 in EXECUTE; ALUWB asserts RegDst=1, RegWrite=1.
- BEQ with Zero=1 -> PCEn=1, PCSrc=01 in BRANCH. With Zero=0 -> PCEn=0; return to FETCH after 3 cycles.
- Op=111111 -> IllegalOp pulses 1 cycle in DECODE; next state FETCH; no write enable asserted.
